fp_addsub_pipe_ctrl: RTL and testbench

FP_ADDSUB_PIPE_CTRL -- requirements
Module: fp_addsub_pipe_ctrl

---
 rtl/fp_addsub_pipe_ctrl_pkg.sv | 19 +
 rtl/fp_expo_diff.sv | 32 +++
 rtl/fp_addsub_pipe_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fp_addsub_pipe_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fp_addsub_pipe_ctrl_pkg
// Shared definitions for the floating-point add/subtract pipeline:
//   - fsm_state_t    : pipeline controller state encoding
//   - DEF_MENT_WIDTH : default mantissa width (hidden bit excluded)
//   - DEF_EXPO_WIDTH : default biased exponent width
// ---------------------------------------------------------------------------
package fp_addsub_pipe_ctrl_pkg;

   localparam int DEF_MENT_WIDTH = 23;
   localparam int DEF_EXPO_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,   // no stage holds a valid operation
      ST_BUSY  = 2'b01,   // at least one stage holds a valid operation
      ST_FLUSH = 2'b10    // pipeline was just emptied by flush
   } fsm_state_t;

endpackage : fp_addsub_pipe_ctrl_pkg

// File: rtl/fp_expo_diff.sv
// ---------------------------------------------------------------------------
// fp_expo_diff
// Combinational exponent comparison for the alignment stage.
// Ports:
//   expo_a, expo_b : biased operand exponents
//   diff           : two's-complement expo_a - expo_b, one bit wider (no wrap)
//   swap           : 1 when expo_b > expo_a (operand b is the larger one)
//   sat            : 1 when |expo_a - expo_b| > MENT_WIDTH+1, i.e. the smaller
//                    operand is shifted entirely past the guard position
// ---------------------------------------------------------------------------
module fp_expo_diff
   import fp_addsub_pipe_ctrl_pkg::*;
#(
   parameter int MENT_WIDTH = DEF_MENT_WIDTH,
   parameter int EXPO_WIDTH = DEF_EXPO_WIDTH
) (
   input  logic [EXPO_WIDTH-1:0] expo_a,
   input  logic [EXPO_WIDTH-1:0] expo_b,
   output logic [EXPO_WIDTH:0]   diff,
   output logic                  swap,
   output logic                  sat
);

   logic [EXPO_WIDTH-1:0] mag;

   // Zero-extend both operands so the subtraction carries the sign bit.
   assign diff = {1'b0, expo_a} - {1'b0, expo_b};
   assign swap = (expo_b > expo_a);
   assign mag  = swap ? (expo_b - expo_a) : (expo_a - expo_b);
   assign sat  = (32'(mag) > 32'(MENT_WIDTH + 1));

endmodule : fp_expo_diff

// File: rtl/fp_addsub_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// fp_addsub_pipe_ctrl
// Pipeline controller for a STAGES-deep floating-point add/subtract datapath.
// Tracks per-stage occupancy with back-pressure, carries op/tag alongside the
// data, registers the exponent alignment info on acceptance and supports a
// one-cycle flush of all in-flight operations.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake; in_op (0 add, 1 sub), in_tag
//   expo_a, expo_b       : operand exponents
//   flush                : discard everything in flight
//   rshift, swap,
//   shift_sat            : registered alignment info of the last accepted pair
//   stage_en             : per-stage load enable
//   stage_valid          : per-stage occupancy
//   out_valid/out_ready  : result handshake; out_op, out_tag of final stage
//   inflight             : number of occupied stages
//   state                : controller state
// ---------------------------------------------------------------------------
module fp_addsub_pipe_ctrl
   import fp_addsub_pipe_ctrl_pkg::*;
#(
   parameter int MENT_WIDTH = DEF_MENT_WIDTH,
   parameter int EXPO_WIDTH = DEF_EXPO_WIDTH,
   parameter int STAGES     = 4,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_op,
   input  logic [TAG_WIDTH-1:0]     in_tag,
   input  logic [EXPO_WIDTH-1:0]    expo_a,
   input  logic [EXPO_WIDTH-1:0]    expo_b,
   input  logic                     flush,
   output logic [EXPO_WIDTH:0]      rshift,
   output logic                     swap,
   output logic                     shift_sat,
   output logic [STAGES-1:0]        stage_en,
   output logic [STAGES-1:0]        stage_valid,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_op,
   output logic [TAG_WIDTH-1:0]     out_tag,
   output logic [$clog2(STAGES):0]  inflight,
   output logic [1:0]               state
);

   localparam int INF_W = $clog2(STAGES) + 1;

   logic [STAGES-1:0]    stage_valid_reg;
   logic [STAGES-1:0]    stage_valid_next;
   logic                 stage_op_reg  [STAGES];
   logic [TAG_WIDTH-1:0] stage_tag_reg [STAGES];
   fsm_state_t           state_reg;
   fsm_state_t           state_next;
   logic                 accept;

   logic [EXPO_WIDTH:0]  diff_w;
   logic                 swap_w;
   logic                 sat_w;
   logic [EXPO_WIDTH:0]  rshift_reg;
   logic                 swap_reg;
   logic                 sat_reg;

   fp_expo_diff #(
      .MENT_WIDTH (MENT_WIDTH),
      .EXPO_WIDTH (EXPO_WIDTH)
   ) u_expo_diff (
      .expo_a (expo_a),
      .expo_b (expo_b),
      .diff   (diff_w),
      .swap   (swap_w),
      .sat    (sat_w)
   );

   // Enables ripple from the output back: a stage may load when it is empty
   // or when the stage ahead of it is loading (its content moves on).
   always_comb begin
      logic [STAGES-1:0] en_v;
      en_v = '0;
      en_v[STAGES-1] = !stage_valid_reg[STAGES-1] || out_ready;
      for (int i = STAGES - 2; i >= 0; i--) begin
         en_v[i] = !stage_valid_reg[i] || en_v[i+1];
      end
      stage_en = en_v;
   end

   assign in_ready = stage_en[0] && (state_reg != ST_FLUSH) && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      stage_valid_next = stage_valid_reg;
      if (flush) begin
         stage_valid_next = '0;
      end else begin
         if (stage_en[0]) stage_valid_next[0] = accept;
         for (int i = 1; i < STAGES; i++) begin
            if (stage_en[i]) stage_valid_next[i] = stage_valid_reg[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stage_valid_reg <= '0;
      else     stage_valid_reg <= stage_valid_next;
   end

   // Op and tag ride along with the valid bits.
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stage_op_reg[gi]  <= 1'b0;
               stage_tag_reg[gi] <= '0;
            end else if (stage_en[gi]) begin
               stage_op_reg[gi]  <= in_op;
               stage_tag_reg[gi] <= in_tag;
            end
         end
      end else begin : g_rest
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stage_op_reg[gi]  <= 1'b0;
               stage_tag_reg[gi] <= '0;
            end else if (stage_en[gi]) begin
               stage_op_reg[gi]  <= stage_op_reg[gi-1];
               stage_tag_reg[gi] <= stage_tag_reg[gi-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rshift_reg <= '0;
         swap_reg   <= 1'b0;
         sat_reg    <= 1'b0;
      end else if (accept) begin
         rshift_reg <= diff_w;
         swap_reg   <= swap_w;
         sat_reg    <= sat_w;
      end
   end

   // State follows occupancy after the edge; flush takes precedence and
   // FLUSH always falls back to IDLE (nothing can be accepted while in it).
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = ST_FLUSH;
      end else begin
         case (state_reg)
            ST_FLUSH: state_next = ST_IDLE;
            ST_IDLE,
            ST_BUSY:  state_next = (|stage_valid_next) ? ST_BUSY : ST_IDLE;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < STAGES; i++) begin
         inflight = inflight + INF_W'(stage_valid_reg[i]);
      end
   end

   assign stage_valid = stage_valid_reg;
   assign out_valid   = stage_valid_reg[STAGES-1];
   assign out_op      = stage_op_reg[STAGES-1];
   assign out_tag     = stage_tag_reg[STAGES-1];
   assign rshift      = rshift_reg;
   assign swap        = swap_reg;
   assign shift_sat   = sat_reg;
   assign state       = state_reg;

endmodule : fp_addsub_pipe_ctrl

// File: tb/tb_fp_addsub_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_pipe_ctrl
// Self-checking bench: directed scenarios plus randomized traffic, compared
// each cycle against a queue-based model of the operations in flight.
// ---------------------------------------------------------------------------
module tb_fp_addsub_pipe_ctrl;

   localparam int S  = 4;
   localparam int TW = 4;
   localparam int EW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_op = 1'b0;
   logic [TW-1:0] in_tag = '0;
   logic [EW-1:0] expo_a = '0;
   logic [EW-1:0] expo_b = '0;
   logic          flush = 1'b0;
   logic [EW:0]   rshift;
   logic          swap;
   logic          shift_sat;
   logic [S-1:0]  stage_en;
   logic [S-1:0]  stage_valid;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_op;
   logic [TW-1:0] out_tag;
   logic [2:0]    inflight;
   logic [1:0]    state;

   fp_addsub_pipe_ctrl #(
      .MENT_WIDTH (23),
      .EXPO_WIDTH (EW),
      .STAGES     (S),
      .TAG_WIDTH  (TW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_tag      (in_tag),
      .expo_a      (expo_a),
      .expo_b      (expo_b),
      .flush       (flush),
      .rshift      (rshift),
      .swap        (swap),
      .shift_sat   (shift_sat),
      .stage_en    (stage_en),
      .stage_valid (stage_valid),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_op      (out_op),
      .out_tag     (out_tag),
      .inflight    (inflight),
      .state       (state)
   );

   always #5 clk = ~clk;

   // Model: each in-flight operation with its current stage position.
   typedef struct {
      logic          op;
      logic [TW-1:0] tag;
      int            pos;
   } item_t;

   item_t q[$];
   int    st_exp    = 0;
   int    rsh_exp   = 0;
   int    swap_exp  = 0;
   int    sat_exp   = 0;
   int    n_checks  = 0;
   int    n_fail    = 0;

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs after the falling edge, check the DUT
   // against the model, then advance the model across the next rising edge.
   task automatic drive_cycle(input logic v, input logic op, input logic [TW-1:0] tag,
                              input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                              input logic fl, input logic ordy,
                              output logic acc, output logic ov);
      item_t   nq[$];
      int      prev_np;
      bit      ret;
      bit      exp_rdy;
      logic [S-1:0] sv_exp;
      int      d;

      @(negedge clk);
      in_valid = v; in_op = op; in_tag = tag; expo_a = ea; expo_b = eb;
      flush = fl; out_ready = ordy;
      #1;

      ret = (q.size() > 0) && (q[0].pos == S - 1) && ordy;
      prev_np = S;
      for (int i = (ret ? 1 : 0); i < q.size(); i++) begin
         item_t it;
         it = q[i];
         if (it.pos < S - 1 && it.pos + 1 < prev_np) it.pos++;
         prev_np = it.pos;
         nq.push_back(it);
      end
      exp_rdy = (prev_np != 0) && !fl && (st_exp != 2);
      acc = v && exp_rdy;

      sv_exp = '0;
      foreach (q[i]) sv_exp[q[i].pos] = 1'b1;

      check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_val("stage_valid", 32'(stage_valid), 32'(sv_exp));
      check_val("inflight", 32'(inflight), 32'(q.size()));
      check_val("state", 32'(state), 32'(st_exp));
      check_val("out_valid", 32'(out_valid), 32'(sv_exp[S-1]));
      if (q.size() > 0 && q[0].pos == S - 1) begin
         check_val("out_tag", 32'(out_tag), 32'(q[0].tag));
         check_val("out_op", 32'(out_op), 32'(q[0].op));
      end
      check_val("rshift", 32'(rshift), 32'(rsh_exp));
      check_val("swap", 32'(swap), 32'(swap_exp));
      check_val("shift_sat", 32'(shift_sat), 32'(sat_exp));
      ov = out_valid;

      if (acc) begin
         d = int'(ea) - int'(eb);
         rsh_exp  = d & 'h1FF;
         swap_exp = (eb > ea) ? 1 : 0;
         sat_exp  = ((d < 0 ? -d : d) > 24) ? 1 : 0;
         $display("ACC tag=%0d op=%0d a=%0d b=%0d", tag, op, ea, eb);
      end

      if (fl) begin
         q.delete();
         st_exp = 2;
      end else begin
         q = nq;
         if (acc) begin
            item_t ni;
            ni.op = op; ni.tag = tag; ni.pos = 0;
            q.push_back(ni);
         end
         st_exp = (q.size() > 0) ? 1 : 0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2;
      in_valid = 1'b0; flush = 1'b0;
      rst = 1'b1;
      #1;
      check_val("rst_stage_valid", 32'(stage_valid), 32'h0);
      check_val("rst_out_valid", 32'(out_valid), 32'h0);
      check_val("rst_rshift", 32'(rshift), 32'h0);
      check_val("rst_swap", 32'(swap), 32'h0);
      check_val("rst_sat", 32'(shift_sat), 32'h0);
      check_val("rst_out_op", 32'(out_op), 32'h0);
      check_val("rst_out_tag", 32'(out_tag), 32'h0);
      check_val("rst_inflight", 32'(inflight), 32'h0);
      check_val("rst_state", 32'(state), 32'h0);
      q.delete();
      st_exp = 0; rsh_exp = 0; swap_exp = 0; sat_exp = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic acc, ov;
      int   cnt, nacc, t;
      int   got_tags[$];

      rst = 1'b1;
      #1;
      check_val("init_state", 32'(state), 32'h0);
      check_val("init_inflight", 32'(inflight), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single op with exact latency.
      drive_cycle(1, 1, 4'd5, 8'd130, 8'd127, 0, 1, acc, ov);
      check_val("single_acc", 32'(acc), 32'h1);
      cnt = 0; ov = 0;
      while (!ov && cnt < 20) begin
         drive_cycle(0, 0, 4'd0, 8'd0, 8'd0, 0, 1, acc, ov);
         cnt++;
         if (cnt == 1) begin
            check_val("rshift_130_127", 32'(rshift), 32'h003);
            check_val("swap_130_127", 32'(swap), 32'h0);
            check_val("sat_130_127", 32'(shift_sat), 32'h0);
         end
      end
      check_val("latency", 32'(cnt), 32'd4);
      check_val("single_tag", 32'(out_tag), 32'd5);
      repeat (2) drive_cycle(0, 0, 4'd0, 8'd0, 8'd0, 0, 1, acc, ov);

      // Negative and saturating differences, plus the non-saturating boundary.
      drive_cycle(1, 0, 4'd1, 8'd0, 8'd255, 0, 1, acc, ov);
      drive_cycle(1, 0, 4'd2, 8'd124, 8'd100, 0, 1, acc, ov);
      check_val("rshift_0_255", 32'(rshift), 32'h101);
      check_val("swap_0_255", 32'(swap), 32'h1);
      check_val("sat_0_255", 32'(shift_sat), 32'h1);
      drive_cycle(1, 0, 4'd3, 8'd100, 8'd125, 0, 1, acc, ov);
      check_val("sat_124_100", 32'(shift_sat), 32'h0);
      check_val("rshift_124_100", 32'(rshift), 32'h018);
      drive_cycle(0, 0, 4'd0, 8'd0, 8'd0, 0, 1, acc, ov);
      check_val("sat_100_125", 32'(shift_sat), 32'h1);
      repeat (6) drive_cycle(0, 0, 4'd0, 8'd0, 8'd0, 0, 1, acc, ov);

      // Back-pressure: offer tags 0..5, out_ready low for the first 6 cycles.
      t = 0; nacc = 0;
      for (int c = 0; c < 40; c++) begin
         logic ordy;
         ordy = (c >= 6);
         drive_cycle(t < 6, 1'(t & 1), 4'(t), 8'(100 + t), 8'd100, 0, ordy, acc, ov);
         if (ov && ordy) got_tags.push_back(int'(out_tag));
         if (acc) t++;
         if (c < 6 && acc) nacc++;
         if (c == 5) begin
            check_val("bp_accepted", 32'(nacc), 32'd4);
            check_val("bp_in_ready", 32'(in_ready), 32'h0);
            check_val("bp_inflight", 32'(inflight), 32'd4);
         end
      end
      check_val("bp_retired_count", 32'(got_tags.size()), 32'd6);
      foreach (got_tags[i]) check_val("bp_order", 32'(got_tags[i]), 32'(i));

      // Flush with three ops in flight and a pair offered on the flush edge.
      for (int i = 1; i <= 3; i++) drive_cycle(1, 0, 4'(i), 8'd10, 8'd20, 0, 1, acc, ov);
      check_val("fl_pre_inflight", 32'(inflight), 32'd2);
      drive_cycle(1, 1, 4'hF, 8'd1, 8'd2, 1, 1, acc, ov);
      check_val("fl_in_ready", 32'(in_ready), 32'h0);
      drive_cycle(0, 0, 4'd0, 8'd0, 8'd0, 0, 1, acc, ov);
      check_val("fl_stage_valid", 32'(stage_valid), 32'h0);
      check_val("fl_state", 32'(state), 32'h2);
      drive_cycle(0, 0, 4'd0, 8'd0, 8'd0, 0, 1, acc, ov);
      check_val("fl_state_idle", 32'(state), 32'h0);
      check_val("fl_ready_back", 32'(in_ready), 32'h1);
      for (int i = 0; i < 6; i++) begin
         drive_cycle(0, 0, 4'd0, 8'd0, 8'd0, 0, 1, acc, ov);
         check_val("fl_no_output", 32'(ov), 32'h0);
      end

      // Continuous stream: one in, one out every cycle once full.
      for (int c = 0; c < 20; c++) begin
         drive_cycle(1, 1'(c & 1), 4'(c), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 0, 1, acc, ov);
         check_val("stream_acc", 32'(acc), 32'h1);
         if (c >= 5) begin
            check_val("stream_inflight", 32'(inflight), 32'd4);
            check_val("stream_state", 32'(state), 32'h1);
         end
      end

      // Asynchronous reset in the middle of the stream.
      pulse_reset();
      drive_cycle(0, 0, 4'd0, 8'd0, 8'd0, 0, 1, acc, ov);
      check_val("post_rst_ready", 32'(in_ready), 32'h1);
      check_val("post_rst_state", 32'(state), 32'h0);

      // Randomized traffic.
      for (int c = 0; c < 500; c++) begin
         drive_cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), $urandom_range(0, 24) == 0,
                     $urandom_range(0, 9) < 6, acc, ov);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_fp_addsub_pipe_ctrl
